// File: rtl/jpeg_hdmi_pkg.sv
// Shared types and frame geometry helpers for the HDMI-to-8x8-block capture path.
package jpeg_hdmi_pkg;

    localparam int BLOCK_SIZE = 8;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURE,
        DRAIN
    } cap_state_t;

    function automatic int blks_per_frame(input int x_res, input int y_res);
        return (x_res / BLOCK_SIZE) * (y_res / BLOCK_SIZE);
    endfunction

endpackage

// File: rtl/blk_stream_checker.sv
// Tracks the converter's block beat stream: block nesting, per-frame block count,
// end-of-frame detection and framing/count error events.
module blk_stream_checker
    import jpeg_hdmi_pkg::*;
#(
    parameter int BLKS  = blks_per_frame(2160, 1200),
    parameter int CNT_W = $clog2(BLKS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             track,
    input  logic             arm,
    input  logic             blk_valid,
    input  logic             blk_sob,
    input  logic             blk_eob,
    input  logic             blk_sof,
    output logic [CNT_W-1:0] blk_cnt,
    output logic             in_block,
    output logic             blk_eof,
    output logic             proto_set,
    output logic             count_set
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(BLKS);

    logic upd;
    logic cnt_full;

    // While armed only the opening sof beat is taken so the frame starts counted.
    assign upd      = blk_valid & (track | (arm & blk_sof));
    assign cnt_full = (blk_cnt == LAST);
    assign blk_eof  = track & blk_valid & blk_eob & cnt_full;

    assign count_set = track & blk_valid &
                       ((blk_sof & (blk_cnt != '0) & !cnt_full) |
                        (blk_sob & !blk_sof & cnt_full));

    assign proto_set = track &
                       ((blk_valid & blk_sob & in_block) |
                        (blk_valid & blk_eob & !in_block & !blk_sob) |
                        (!blk_valid & in_block) |
                        (blk_valid & blk_sof & !blk_sob));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_block <= 1'b0;
            blk_cnt  <= '0;
        end else if (upd) begin
            if (blk_eob) begin
                in_block <= 1'b0;
            end else if (blk_sob) begin
                in_block <= 1'b1;
            end

            if (blk_eof) begin
                blk_cnt <= '0;
            end else if (blk_sof) begin
                blk_cnt <= CNT_W'(1);
            end else if (blk_sob && !cnt_full) begin
                blk_cnt <= blk_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/hdmi_capture_ctrl.sv
// Frame-level sequencer for the HDMI-to-8x8-block converter: command FSM, converter
// enable, arming timeout, frame counting and sticky error/status reporting.
module hdmi_capture_ctrl
    import jpeg_hdmi_pkg::*;
#(
    parameter int X_RES          = 2160,
    parameter int Y_RES          = 1200,
    parameter int TIMEOUT_FRAMES = 2,
    parameter int FRAME_CNT_W    = 16
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic                                             cmd_start,
    input  logic                                             cmd_single,
    input  logic                                             cmd_stop,
    input  logic                                             err_clr,
    input  logic                                             hdmi_v_sync,
    input  logic                                             blk_valid,
    input  logic                                             blk_sob,
    input  logic                                             blk_eob,
    input  logic                                             blk_sof,
    output logic                                             cap_en,
    output logic                                             blk_eof,
    output logic                                             frame_done,
    output logic                                             busy,
    output logic [FRAME_CNT_W-1:0]                           frame_cnt,
    output logic [$clog2(blks_per_frame(X_RES, Y_RES)+1)-1:0] blk_cnt,
    output logic                                             err_blk_count,
    output logic                                             err_proto,
    output logic                                             err_timeout
);

    localparam int BLKS  = blks_per_frame(X_RES, Y_RES);
    localparam int CNT_W = $clog2(BLKS + 1);
    localparam int TO_W  = $clog2(TIMEOUT_FRAMES + 2);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_FRAMES);
    localparam logic [TO_W-1:0] TO_MAX   = TO_W'(TIMEOUT_FRAMES + 1);

    cap_state_t      state, state_nxt;
    logic            single, single_nxt;
    logic            cap_en_nxt;
    logic            vs_q;
    logic            vs_fall;
    logic [TO_W-1:0] to_cnt;
    logic            timeout_set;
    logic            in_block;
    logic            proto_set;
    logic            count_set;

    assign vs_fall     = vs_q & !hdmi_v_sync;
    assign busy        = (state != IDLE);
    assign timeout_set = (state == ARMED) & vs_fall & (to_cnt == TO_LIMIT);

    blk_stream_checker #(
        .BLKS  (BLKS),
        .CNT_W (CNT_W)
    ) u_checker (
        .clk       (clk),
        .rst_n     (rst_n),
        .track     ((state == CAPTURE) || (state == DRAIN)),
        .arm       (state == ARMED),
        .blk_valid (blk_valid),
        .blk_sob   (blk_sob),
        .blk_eob   (blk_eob),
        .blk_sof   (blk_sof),
        .blk_cnt   (blk_cnt),
        .in_block  (in_block),
        .blk_eof   (blk_eof),
        .proto_set (proto_set),
        .count_set (count_set)
    );

    always_comb begin
        state_nxt  = state;
        single_nxt = single;
        unique case (state)
            IDLE: begin
                if (!cmd_stop && (cmd_start || cmd_single)) begin
                    state_nxt  = ARMED;
                    single_nxt = cmd_single;
                end
            end
            ARMED: begin
                if (cmd_stop) begin
                    state_nxt = IDLE;
                end else if (blk_valid && blk_sof) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                // A stop landing on the last eob has nothing left to drain.
                if (blk_eof && (single || cmd_stop)) begin
                    state_nxt = IDLE;
                end else if (cmd_stop) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (blk_eof || (vs_fall && !in_block && (blk_cnt == '0))) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (state_nxt == IDLE) begin
            single_nxt = 1'b0;
        end
        cap_en_nxt = (state_nxt == ARMED) || ((state_nxt == CAPTURE) && !single_nxt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            single <= 1'b0;
            cap_en <= 1'b0;
            vs_q   <= 1'b0;
            to_cnt <= '0;
        end else begin
            state  <= state_nxt;
            single <= single_nxt;
            cap_en <= cap_en_nxt;
            vs_q   <= hdmi_v_sync;
            if (state != ARMED) begin
                to_cnt <= '0;
            end else if (vs_fall && (to_cnt != TO_MAX)) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt     <= '0;
            frame_done    <= 1'b0;
            err_blk_count <= 1'b0;
            err_proto     <= 1'b0;
            err_timeout   <= 1'b0;
        end else begin
            frame_done <= blk_eof;
            if (blk_eof) begin
                frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
            end
            // A new error event wins over a simultaneous clear.
            err_blk_count <= count_set   | (err_blk_count & !err_clr);
            err_proto     <= proto_set   | (err_proto & !err_clr);
            err_timeout   <= timeout_set | (err_timeout & !err_clr);
        end
    end

endmodule

// File: tb/tb_hdmi_capture_ctrl.sv
// Directed bench for hdmi_capture_ctrl on a 16x16 frame (4 blocks of 32 beats).
`timescale 1ns/1ps
module tb_hdmi_capture_ctrl;

    localparam int BEATS = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_start = 1'b0;
    logic        cmd_single = 1'b0;
    logic        cmd_stop = 1'b0;
    logic        err_clr = 1'b0;
    logic        hdmi_v_sync = 1'b0;
    logic        blk_valid = 1'b0;
    logic        blk_sob = 1'b0;
    logic        blk_eob = 1'b0;
    logic        blk_sof = 1'b0;
    logic        cap_en;
    logic        blk_eof;
    logic        frame_done;
    logic        busy;
    logic [15:0] frame_cnt;
    logic [2:0]  blk_cnt;
    logic        err_blk_count;
    logic        err_proto;
    logic        err_timeout;

    int n_chk = 0;
    int n_fail = 0;
    int fd_cycles = 0;

    hdmi_capture_ctrl #(
        .X_RES          (16),
        .Y_RES          (16),
        .TIMEOUT_FRAMES (2),
        .FRAME_CNT_W    (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_start     (cmd_start),
        .cmd_single    (cmd_single),
        .cmd_stop      (cmd_stop),
        .err_clr       (err_clr),
        .hdmi_v_sync   (hdmi_v_sync),
        .blk_valid     (blk_valid),
        .blk_sob       (blk_sob),
        .blk_eob       (blk_eob),
        .blk_sof       (blk_sof),
        .cap_en        (cap_en),
        .blk_eof       (blk_eof),
        .frame_done    (frame_done),
        .busy          (busy),
        .frame_cnt     (frame_cnt),
        .blk_cnt       (blk_cnt),
        .err_blk_count (err_blk_count),
        .err_proto     (err_proto),
        .err_timeout   (err_timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_done === 1'b1) fd_cycles++;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        {cmd_start, cmd_single, cmd_stop, err_clr, hdmi_v_sync} = '0;
        {blk_valid, blk_sob, blk_eob, blk_sof} = '0;
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic command(input logic s, input logic g, input logic p);
        cmd_start = s;
        cmd_single = g;
        cmd_stop = p;
        cycle();
        {cmd_start, cmd_single, cmd_stop} = '0;
    endtask

    task automatic vsync();
        hdmi_v_sync = 1'b1;
        cycle();
        cycle();
        hdmi_v_sync = 1'b0;
        cycle();
        cycle();
    endtask

    task automatic beat(input logic v, input logic s, input logic e, input logic f, input logic c);
        blk_valid = v;
        blk_sob = s;
        blk_eob = e;
        blk_sof = f;
        err_clr = c;
        cycle();
        {blk_valid, blk_sob, blk_eob, blk_sof, err_clr} = '0;
    endtask

    // One block of BEATS beats; reports blk_eof on the eob beat, cap_en after the
    // first beat and cap_en after the beat carrying cmd_stop (stop_beat < 0: none).
    task automatic send_block(input logic first, input int stop_beat,
                              output logic eof_last, output logic cap1, output logic capstop);
        eof_last = 1'b0;
        cap1 = 1'b0;
        capstop = 1'b0;
        for (int i = 0; i < BEATS; i++) begin
            blk_valid = 1'b1;
            blk_sob = (i == 0);
            blk_eob = (i == BEATS - 1);
            blk_sof = first && (i == 0);
            cmd_stop = (i == stop_beat);
            @(negedge clk);
            if (i == BEATS - 1) eof_last = blk_eof;
            cycle();
            if (i == 0) cap1 = cap_en;
            if (i == stop_beat) capstop = cap_en;
        end
        {blk_valid, blk_sob, blk_eob, blk_sof, cmd_stop} = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cycle();
        n_chk++; if (cap_en !== 1'b0) begin n_fail++; $display("FAIL reset_cap_en: got %b want 0", cap_en); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_chk++; if (frame_cnt !== 16'd0 || blk_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_counts: got %0d/%0d want 0/0", frame_cnt, blk_cnt); end
        n_chk++; if ({frame_done, err_blk_count, err_proto, err_timeout} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {frame_done, err_blk_count, err_proto, err_timeout}); end
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_continuous();
        logic e, c1, cs, exp_e;
        int fd0;
        do_reset();
        fd0 = fd_cycles;
        command(1'b1, 1'b0, 1'b0);
        n_chk++; if (cap_en !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL cont_armed: got cap_en=%b busy=%b want 1 1", cap_en, busy); end
        for (int f = 0; f < 3; f++) begin
            vsync();
            for (int b = 0; b < 4; b++) begin
                send_block(b == 0, -1, e, c1, cs);
                exp_e = (b == 3);
                n_chk++; if (e !== exp_e) begin n_fail++; $display("FAIL cont_eof_f%0d_b%0d: got %b want %b", f, b, e, exp_e); end
            end
        end
        cycle();
        n_chk++; if (frame_cnt !== 16'd3) begin n_fail++; $display("FAIL cont_frame_cnt: got %0d want 3", frame_cnt); end
        n_chk++; if ({err_blk_count, err_proto, err_timeout} !== 3'b000) begin n_fail++; $display("FAIL cont_errors: got %b want 000", {err_blk_count, err_proto, err_timeout}); end
        n_chk++; if (busy !== 1'b1 || cap_en !== 1'b1 || blk_cnt !== 3'd0) begin n_fail++; $display("FAIL cont_status: got busy=%b cap_en=%b blk_cnt=%0d want 1 1 0", busy, cap_en, blk_cnt); end
        n_chk++; if (fd_cycles - fd0 !== 3) begin n_fail++; $display("FAIL cont_frame_done: got %0d pulses want 3", fd_cycles - fd0); end
        command(1'b0, 1'b0, 1'b1);
        n_chk++; if (cap_en !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL cont_drain: got cap_en=%b busy=%b want 0 1", cap_en, busy); end
        vsync();
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cont_stop_between: got busy=%b want 0", busy); end
    endtask

    task automatic test_single();
        logic e, c1, cs;
        int fd0;
        do_reset();
        fd0 = fd_cycles;
        command(1'b0, 1'b1, 1'b0);
        n_chk++; if (cap_en !== 1'b1) begin n_fail++; $display("FAIL single_armed: got cap_en=%b want 1", cap_en); end
        vsync();
        send_block(1'b1, -1, e, c1, cs);
        n_chk++; if (c1 !== 1'b0) begin n_fail++; $display("FAIL single_cap_drop: got cap_en=%b want 0", c1); end
        send_block(1'b0, -1, e, c1, cs);
        send_block(1'b0, -1, e, c1, cs);
        send_block(1'b0, -1, e, c1, cs);
        n_chk++; if (e !== 1'b1) begin n_fail++; $display("FAIL single_eof: got %b want 1", e); end
        n_chk++; if (busy !== 1'b0 || frame_done !== 1'b1) begin n_fail++; $display("FAIL single_end: got busy=%b frame_done=%b want 0 1", busy, frame_done); end
        cycle();
        n_chk++; if (frame_done !== 1'b0 || frame_cnt !== 16'd1) begin n_fail++; $display("FAIL single_after: got frame_done=%b frame_cnt=%0d want 0 1", frame_done, frame_cnt); end
        n_chk++; if (fd_cycles - fd0 !== 1) begin n_fail++; $display("FAIL single_pulse: got %0d cycles want 1", fd_cycles - fd0); end
    endtask

    task automatic test_stop_drain();
        logic e, c1, cs;
        do_reset();
        command(1'b1, 1'b0, 1'b0);
        vsync();
        send_block(1'b1, -1, e, c1, cs);
        send_block(1'b0, 10, e, c1, cs);
        n_chk++; if (cs !== 1'b0) begin n_fail++; $display("FAIL stop_cap_en: got %b want 0", cs); end
        n_chk++; if (busy !== 1'b1 || cap_en !== 1'b0) begin n_fail++; $display("FAIL stop_drain: got busy=%b cap_en=%b want 1 0", busy, cap_en); end
        send_block(1'b0, -1, e, c1, cs);
        n_chk++; if (blk_cnt !== 3'd3) begin n_fail++; $display("FAIL stop_blk_cnt: got %0d want 3", blk_cnt); end
        send_block(1'b0, -1, e, c1, cs);
        n_chk++; if (e !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL stop_end: got eof=%b busy=%b want 1 0", e, busy); end
        n_chk++; if (frame_cnt !== 16'd1 || {err_blk_count, err_proto} !== 2'b00) begin n_fail++; $display("FAIL stop_result: got frame_cnt=%0d errs=%b want 1 00", frame_cnt, {err_blk_count, err_proto}); end
    endtask

    task automatic test_blk_count();
        logic e, c1, cs;
        do_reset();
        command(1'b1, 1'b0, 1'b0);
        vsync();
        for (int b = 0; b < 3; b++) send_block(b == 0, -1, e, c1, cs);
        n_chk++; if (err_blk_count !== 1'b0) begin n_fail++; $display("FAIL cnt_before: got %b want 0", err_blk_count); end
        send_block(1'b1, -1, e, c1, cs);
        n_chk++; if (err_blk_count !== 1'b1 || blk_cnt !== 3'd1) begin n_fail++; $display("FAIL cnt_short: got err=%b blk_cnt=%0d want 1 1", err_blk_count, blk_cnt); end
        n_chk++; if (err_proto !== 1'b0) begin n_fail++; $display("FAIL cnt_proto: got %b want 0", err_proto); end
        beat(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_chk++; if (err_blk_count !== 1'b0) begin n_fail++; $display("FAIL cnt_clr: got %b want 0", err_blk_count); end
    endtask

    task automatic test_proto();
        do_reset();
        command(1'b1, 1'b0, 1'b0);
        vsync();
        beat(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) beat(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_chk++; if (err_proto !== 1'b0) begin n_fail++; $display("FAIL proto_clean: got %b want 0", err_proto); end
        beat(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        n_chk++; if (err_proto !== 1'b1) begin n_fail++; $display("FAIL proto_dup_sob: got %b want 1", err_proto); end
        beat(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        n_chk++; if (err_proto !== 1'b0) begin n_fail++; $display("FAIL proto_clr: got %b want 0", err_proto); end
        beat(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_chk++; if (err_proto !== 1'b1) begin n_fail++; $display("FAIL proto_gap_vs_clr: got %b want 1", err_proto); end
        beat(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        n_chk++; if (err_proto !== 1'b0) begin n_fail++; $display("FAIL proto_clr2: got %b want 0", err_proto); end
        beat(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle();
        n_chk++; if (err_proto !== 1'b0) begin n_fail++; $display("FAIL proto_eob: got %b want 0", err_proto); end
    endtask

    task automatic test_timeout();
        do_reset();
        command(1'b1, 1'b0, 1'b1);
        n_chk++; if (busy !== 1'b0 || cap_en !== 1'b0) begin n_fail++; $display("FAIL to_start_stop: got busy=%b cap_en=%b want 0 0", busy, cap_en); end
        command(1'b1, 1'b0, 1'b0);
        vsync();
        vsync();
        n_chk++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL to_early: got %b want 0", err_timeout); end
        hdmi_v_sync = 1'b1;
        cycle();
        cycle();
        hdmi_v_sync = 1'b0;
        cycle();
        n_chk++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL to_third_fall: got %b want 1", err_timeout); end
        n_chk++; if (busy !== 1'b1 || cap_en !== 1'b1) begin n_fail++; $display("FAIL to_armed: got busy=%b cap_en=%b want 1 1", busy, cap_en); end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_single();
        test_stop_drain();
        test_blk_count();
        test_proto();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hdmi_capture_ctrl.md
Name: hdmi_capture_ctrl

Overview:
Frame-level sequencer for the HDMI-to-8x8-block converter. It drives the converter's enable from start/stop/single-shot commands and tracks the converter's block output stream. It counts blocks per frame, flags end of frame, checks sob/eob/sof framing and reports sticky errors and status to the register bank. It sits beside the converter, between the configuration registers and the JPEG block pipeline.

Parameters:
X_RES, 2160, frame width in pixels; multiple of 8
Y_RES, 1200, frame height in pixels; multiple of 8
TIMEOUT_FRAMES, 2, v_sync falling edges tolerated in ARMED without a blk_sof
FRAME_CNT_W, 16, width of frame_cnt

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_start  in  1  pulse: begin continuous capture
cmd_single  in  1  pulse: capture exactly one frame
cmd_stop  in  1  pulse: stop after the current frame
err_clr  in  1  pulse: clear sticky errors
hdmi_v_sync  in  1  HDMI vertical sync, same as the converter's input
blk_valid  in  1  converter block beat valid
blk_sob  in  1  converter start of block
blk_eob  in  1  converter end of block
blk_sof  in  1  converter start of frame
cap_en  out  1  enable to the converter
blk_eof  out  1  combinational; high on the eob beat of the last block of the frame
frame_done  out  1  registered 1-cycle pulse, one cycle after blk_eof
busy  out  1  state != IDLE
frame_cnt  out  FRAME_CNT_W  completed frames, wraps
blk_cnt  out  clog2(BLKS+1)  blocks seen in current frame; BLKS = (X_RES/8)*(Y_RES/8)
err_blk_count  out  1  sticky: frame with block count != BLKS
err_proto  out  1  sticky: sob/eob framing violation
err_timeout  out  1  sticky: no data after arming

Behaviour:
- Reset: state IDLE; cap_en, frame_done, frame_cnt, blk_cnt, in_block, single flag and all err_* = 0.
- FSM states: IDLE, ARMED, CAPTURE, DRAIN.
- IDLE: cap_en=0. cmd_start or cmd_single -> ARMED. The single flag is set on cmd_single.
- ARMED: cap_en=1. The converter samples en on the v_sync falling edge.
  - Count v_sync falling edges (registered v_sync, compared with the current value).
  - valid&sof -> CAPTURE.
  - Edge count reaching TIMEOUT_FRAMES+1 -> set err_timeout and stay ARMED; the count saturates.
  - cmd_stop -> IDLE.
- CAPTURE: cap_en=1, except cap_en=0 when the single flag is set.
  - blk_eof (valid & eob & blk_cnt==BLKS) -> frame_cnt+1, frame_done next cycle.
  - If the single flag is set at blk_eof -> IDLE and the flag clears. Otherwise stay and wait for the next sof.
  - cmd_stop -> DRAIN, cap_en drops the same cycle.
- DRAIN: cap_en=0. blk_eof -> IDLE.
  - A v_sync falling edge with in_block=0 and blk_cnt==0 -> IDLE. This covers a stop issued between frames.
- Commands in states not listed are ignored. cmd_stop has priority over cmd_start/cmd_single in the same cycle.
- blk_cnt, updated only in CAPTURE/DRAIN on valid beats:
  - sof -> 1. If the previous blk_cnt was neither 0 nor BLKS, set err_blk_count (short frame).
  - sob without sof -> +1. A sob while blk_cnt==BLKS sets err_blk_count (long frame) and saturates.
  - Cleared to 0 after blk_eof.
  - In ARMED, the first sof loads 1.
- in_block: set on valid&sob, cleared on valid&eob; an eob with sob on the same beat leaves it 0 (N=8 case).
- err_proto is set (CAPTURE/DRAIN only) on any of:
  - sob while in_block=1
  - eob while in_block=0 without sob on the same beat
  - blk_valid=0 while in_block=1
  - sof without sob
- err_clr clears all err_*. If an error event occurs in the same cycle as err_clr, the set wins.
- Latency: cap_en changes 1 cycle after a command. blk_eof has 0 cycles of latency from its inputs.

Decomposition:
- Package jpeg_hdmi_pkg:
  - BLOCK_SIZE=8
  - blocks-per-frame function blks_per_frame(X_RES,Y_RES)
  - enum cap_state_t {IDLE,ARMED,CAPTURE,DRAIN}
- One natural sub-module: blk_stream_checker. It owns in_block, blk_cnt, blk_eof and the err_proto/err_blk_count set pulses.
- The FSM, the command handling and the timeout logic stay in the top module.

Test Plan (X_RES=16, Y_RES=16, N=2 -> BLKS=4, 32 beats/block):
- cmd_start, then 3 frames of 4 well-formed blocks -> blk_eof exactly on the 4th eob of each frame, frame_cnt=3, no errors, busy=1.
- cmd_single during IDLE -> cap_en=1, cap_en=0 one cycle after sof, IDLE after 4th-block eof, frame_cnt=1, frame_done one 1-cycle pulse.
- Capturing, cmd_stop during block 2 -> cap_en=0 next cycle, state DRAIN, blocks 3-4 counted, IDLE after eof, frame_cnt+1.
- Frame of 3 blocks then sof -> err_blk_count=1, blk_cnt=1. Then err_clr -> err_blk_count=0.
- sob repeated without eob, and blk_valid dropped mid-block -> err_proto=1 both times. err_clr in the same cycle as a new violation -> stays 1.
- cmd_start with no converter output over 3 v_sync falls -> err_timeout=1 on the 3rd fall, state ARMED. cmd_start+cmd_stop in the same cycle from IDLE -> stays IDLE.
